// File: rtl/bor_por_puc_ctrl_if.sv
// Pin, acknowledge and vector-index signals of the reset-source daisy-chain stage.
// master drives the pin/upstream inputs; slave is the bor_por_puc_ctrl side.
interface bor_por_puc_ctrl_if;
    logic       RSTn;
    logic       INTACKin;
    logic [5:0] IntAddrthru;
    logic       req;
    logic       INTACKthru;
    logic [5:0] IntAddrout;

    modport master (
        output RSTn, INTACKin, IntAddrthru,
        input  req, INTACKthru, IntAddrout
    );

    modport slave (
        input  RSTn, INTACKin, IntAddrthru,
        output req, INTACKthru, IntAddrout
    );
endinterface

// File: rtl/bor_por_puc_ctrl.sv
// Reset source at the top of the interrupt daisy chain: stretches RST / RSTn into a PUC request.
// Optional RSTN_FILTER_EN adds a MIN_LOW-sample glitch filter after the RSTn synchronizer.
module bor_por_puc_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter logic [5:0]  RESET_VECTOR = 6'd63,
    parameter int unsigned MIN_LOW      = 2
) (
    input  logic              MCLK,
    input  logic              RST,
    bor_por_puc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

    localparam logic [7:0] LP_HOLD = 8'(HOLD_CYCLES);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_sync;
    logic       w_rstn_s;
    logic       w_low;
    logic       w_req;

    always_ff @(posedge MCLK) begin
        if (RST) r_sync <= '1;
        else     r_sync <= {r_sync[0], bus.RSTn};
    end

    assign w_rstn_s = r_sync[1];

`ifdef RSTN_FILTER_EN
    logic [7:0] r_flt;

    always_ff @(posedge MCLK) begin
        if (RST || w_rstn_s)  r_flt <= '0;
        else if (r_flt != '1) r_flt <= r_flt + 8'd1;
    end

    // r_flt counts earlier consecutive lows; the current sample makes it r_flt+1
    assign w_low = !w_rstn_s && ((32'(r_flt) + 32'd1) >= MIN_LOW);
`else
    assign w_low = !w_rstn_s;
`endif

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state <= HOLD;
            r_cnt   <= LP_HOLD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_low) w_state_nxt = ASSERT;
            end
            ASSERT: begin
                if (w_rstn_s) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = LP_HOLD;
                end
            end
            HOLD: begin
                // a new low wins over counter expiry so the sequence restarts
                if (w_low)              w_state_nxt = ASSERT;
                else if (r_cnt <= 8'd1) w_state_nxt = IDLE;
                else                    w_cnt_nxt   = r_cnt - 8'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_req          = (r_state != IDLE);
    assign bus.req        = w_req;
    assign bus.IntAddrout = w_req ? RESET_VECTOR : bus.IntAddrthru;
    assign bus.INTACKthru = bus.INTACKin & ~w_req;
endmodule

// File: tb/tb_bor_por_puc_ctrl.sv
// Directed self-checking bench for bor_por_puc_ctrl (HOLD_CYCLES=8, RESET_VECTOR=63, MIN_LOW=2).
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_bor_por_puc_ctrl;
    logic MCLK;
    logic RST;
    int   checks;
    int   errors;

    bor_por_puc_ctrl_if bus ();

    bor_por_puc_ctrl #(
        .HOLD_CYCLES  (8),
        .RESET_VECTOR (6'd63),
        .MIN_LOW      (2)
    ) dut (
        .MCLK (MCLK),
        .RST  (RST),
        .bus  (bus)
    );

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic exp_req);
        chk(tag, 8'(bus.req), 8'(exp_req));
        chk({tag, "_addr"}, 8'(bus.IntAddrout), exp_req ? 8'd63 : 8'(bus.IntAddrthru));
    endtask

    logic bounce_v [0:5];

    initial begin
        checks = 0;
        errors = 0;
        RST             = 1'b1;
        bus.RSTn        = 1'b1;
        bus.INTACKin    = 1'b0;
        bus.IntAddrthru = 6'd5;

        // power-up: one RST cycle -> req for 8 cycles
        tick();
        RST = 1'b0;
        chk_req("por_first", 1'b1);
        chk("por_ackthru", 8'(bus.INTACKthru), 8'd0);
        bus.INTACKin = 1'b1;
        #1;
        chk("por_ack_blocked", 8'(bus.INTACKthru), 8'd0);
        bus.INTACKin = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk_req("por_hold", 1'b1);
        end
        tick();
        chk_req("por_release", 1'b0);
        chk("por_addr_thru", 8'(bus.IntAddrout), 8'd5);

        // idle feedthrough
        bus.IntAddrthru = 6'd2;
        #1;
        chk("ft_addr", 8'(bus.IntAddrout), 8'd2);
        bus.IntAddrthru = 6'd5;
        #1;
        chk("ft_addr_back", 8'(bus.IntAddrout), 8'd5);
        bus.INTACKin = 1'b1;
        #1;
        chk("ft_ack_hi", 8'(bus.INTACKthru), 8'd1);
        bus.INTACKin = 1'b0;
        #1;
        chk("ft_ack_lo", 8'(bus.INTACKthru), 8'd0);

        // pin reset: 3-cycle low, req after 3 edges, then 2 sync + 8 hold after release
        bus.RSTn = 1'b0;
        tick(); chk_req("pin_p1", 1'b0);
        tick(); chk_req("pin_p2", 1'b0);
        tick(); chk_req("pin_p3", 1'b1);
        bus.RSTn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_req("pin_hi", 1'b1);
            if (i == 5) begin
                bus.INTACKin = 1'b1;
                #1;
                chk("pin_ack_blocked", 8'(bus.INTACKthru), 8'd0);
                bus.INTACKin = 1'b0;
            end
        end
        tick();
        chk_req("pin_fall", 1'b0);

        // bounce: 0,1,0,1,0,1 then high; req from edge 3 through edge 15
        bounce_v[0] = 1'b0; bounce_v[1] = 1'b1; bounce_v[2] = 1'b0;
        bounce_v[3] = 1'b1; bounce_v[4] = 1'b0; bounce_v[5] = 1'b1;
        bus.RSTn = bounce_v[0];
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk_req("bounce", (k >= 3 && k <= 15));
            bus.RSTn = (k <= 5) ? bounce_v[k] : 1'b1;
        end

        // RST overrides a low pin and re-initialises the synchronizer
        bus.RSTn = 1'b0;
        tick(); chk_req("prio_pre1", 1'b0);
        tick(); chk_req("prio_pre2", 1'b0);
        RST = 1'b1;
        tick();
        RST      = 1'b0;
        bus.RSTn = 1'b1;
        chk_req("prio_e0", 1'b1);
        // low sampled at edge 6 reaches the state logic exactly as the counter expires
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk_req("expire_collide", (k <= 16));
            if (k == 5) bus.RSTn = 1'b0;
            if (k == 6) bus.RSTn = 1'b1;
        end

`ifdef RSTN_FILTER_EN
        bus.RSTn = 1'b0;
        tick();
        bus.RSTn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_req("flt_glitch", 1'b0);
        end
        bus.RSTn = 1'b0;
        tick();
        tick();
        bus.RSTn = 1'b1;
        tick();
        tick();
        chk_req("flt_two_low", 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
